calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Clocked mode/sequence controller for the keypad calculator-stopwatch. It replaces the combinational mode latch with a registered FSM. It turns debounced keypad events into operand entry (x, y), operation selection, a start/done handshake with the calculator datapath, and forwarding of stopwatch commands. It sits between the keypad scanner and the calculator, stopwatch and display muxes.

Parameters:
CALC_TIMEOUT, 255, max cycles to wait for calc_done after calc_start before aborting with error.
MAX_DIGITS, 2, decimal digits per operand (the 7-bit x/y holds 0..99).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  level high while a key is held (scanner "pressed"); synchronous to clk
key_code  input  4  key code, valid while key_valid=1: 0-9 digits, 10=A, 11=B, 12=C, 13=D, 14=*, 15=#
calc_done  input  1  one-cycle pulse from calculator, result valid
calc_result  input  14  calculator magnitude
calc_sign  input  1  calculator negative flag
mode  output  1  0=stopwatch display, 1=calculator display
x  output  7  operand X, 0..99
y  output  7  operand Y, 0..99
op  output  2  operation select 0..3
calc_start  output  1  one-cycle start pulse
result  output  14  latched result
result_neg  output  1  latched sign
result_valid  output  1  high in SHOW state with a successful result
error  output  1  high in SHOW after a timeout
led_x  output  1  editing X
led_y  output  1  editing Y
crono_stb  output  1  one-cycle strobe forwarding a key to the stopwatch
crono_key  output  4  forwarded key code, held until the next strobe

Behaviour:
- Reset (async, rst_n=0): state=CRONO; mode, x, y, op, calc_start, result, result_neg, result_valid, error, led_x, led_y, crono_stb, crono_key all 0; key edge register=0.
- Key event: key_valid=1 while the registered previous key_valid=0. One event per press, regardless of hold length. key_code is sampled in the same cycle. Effects are visible in registered outputs the cycle after.
- States: CRONO, EDIT_X, EDIT_Y, START, WAIT, SHOW.
- CRONO (mode=0):
  - '*' -> EDIT_X.
  - Any other key -> crono_stb=1 for one cycle, crono_key=key_code, state unchanged.
- EDIT_X and EDIT_Y (mode=1; led_x=1 only in EDIT_X, led_y=1 only in EDIT_Y):
  - Digit d -> operand = (operand % 10)*10 + d, so the oldest digit drops and the value never exceeds 99.
  - A -> op = op+1, wrapping 3->0.
  - B -> toggle between EDIT_X and EDIT_Y.
  - C -> clear the currently edited operand to 0.
  - '#' -> START.
  - D -> CRONO; x, y and op are retained.
  - '*' is ignored.
- START: calc_start=1 for exactly one cycle. x, y and op are frozen from START until leaving WAIT. Next state is WAIT and the timeout counter is set to 0.
- WAIT:
  - calc_done=1 -> latch calc_result and calc_sign, result_valid=1, error=0, go to SHOW.
  - Counter reaches CALC_TIMEOUT with no done -> error=1, result_valid=0, result unchanged, go to SHOW.
  - Key D -> CRONO (abort); a later calc_done is ignored.
  - All other keys are ignored.
  - If calc_done and D coincide, D wins and the result is not latched.
- SHOW:
  - C -> x=y=op=0, result_valid=0, error=0, go to EDIT_X.
  - '*' -> EDIT_X with values kept, result_valid and error cleared.
  - D -> CRONO.
  - '#' -> START (recompute).
  - Digits, A and B are ignored.
- calc_done outside WAIT is ignored.
- crono_stb is never asserted outside CRONO.
- Reset mid-WAIT: immediate return to the reset values; calc_start is not re-issued.
- Timeout counter is 8 bits wide minimum, clog2(CALC_TIMEOUT+1) in general.

Test Plan:
- Reset, then press 5 in CRONO -> crono_stb pulses once, crono_key=5, mode=0, x=0.
- '*', then 4, 2 -> mode=1, led_x=1, x=42. Then 7 -> x=27 (shift, drop oldest).
- '*', 1, 2, B, 3, A, A, '#', with calc_done 3 cycles after calc_start and calc_result=100, sign=0 -> x=12, y=3, op=2. calc_start is high exactly one cycle. SHOW shows result=100, result_valid=1.
- '#' with calc_done never asserted, CALC_TIMEOUT=255 -> SHOW entered 255 cycles after WAIT entry, error=1, result_valid=0.
- Hold key 9 for 50 cycles in EDIT_Y -> y changes once. Press D during WAIT and pulse calc_done in the same cycle -> CRONO, result not updated.
- Assert rst_n=0 mid-WAIT -> all outputs 0 asynchronously, state CRONO after release.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// ---------------------------------------------------------------------------
// calc_sequencer_if
// Purpose : bundles the keypad, calculator handshake and display-side signals
//           of the calculator-stopwatch sequencer into one interface.
// Signals : key_valid/key_code        keypad scanner (level, debounced)
//           calc_done/result/sign     calculator completion and value
//           calc_start                one-cycle start pulse to the calculator
//           mode/x/y/op/led_x/led_y   display and operand state
//           result/result_neg/...     latched calculation outcome
//           crono_stb/crono_key       key forwarding to the stopwatch
// Modports: master = the sequencer, slave = the surrounding system.
// ---------------------------------------------------------------------------
interface calc_sequencer_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        calc_done;
  logic [13:0] calc_result;
  logic        calc_sign;
  logic        mode;
  logic [6:0]  x;
  logic [6:0]  y;
  logic [1:0]  op;
  logic        calc_start;
  logic [13:0] result;
  logic        result_neg;
  logic        result_valid;
  logic        error;
  logic        led_x;
  logic        led_y;
  logic        crono_stb;
  logic [3:0]  crono_key;

  modport master (
    input  key_valid, key_code, calc_done, calc_result, calc_sign,
    output mode, x, y, op, calc_start, result, result_neg, result_valid,
           error, led_x, led_y, crono_stb, crono_key
  );

  modport slave (
    output key_valid, key_code, calc_done, calc_result, calc_sign,
    input  mode, x, y, op, calc_start, result, result_neg, result_valid,
           error, led_x, led_y, crono_stb, crono_key
  );
endinterface

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
// Purpose : registered mode/sequence controller for the keypad
//           calculator-stopwatch. Turns keypad presses into operand entry,
//           operation selection, a start/done handshake with the calculator
//           and forwarding of stopwatch commands.
// Ports   : clk    system clock, rising edge
//           rst_n  asynchronous active-low reset
//           bus    calc_sequencer_if.master (keypad, calculator, outputs)
// Params  : CALC_TIMEOUT  cycles to wait for calc_done before flagging error
//           MAX_DIGITS    decimal digits kept per operand
// ---------------------------------------------------------------------------
module calc_sequencer #(
  parameter int CALC_TIMEOUT = 255,
  parameter int MAX_DIGITS   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  calc_sequencer_if.master   bus
);

  localparam int CNT_W     = ($clog2(CALC_TIMEOUT + 1) < 8) ? 8 : $clog2(CALC_TIMEOUT + 1);
  localparam int DIGIT_MOD = 10 ** (MAX_DIGITS - 1);

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [2:0] {
    CRONO  = 3'd0,
    EDIT_X = 3'd1,
    EDIT_Y = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    SHOW   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             key_prev_q;
  logic [6:0]       x_q, x_d, y_q, y_d;
  logic [1:0]       op_q, op_d;
  logic [13:0]      result_q, result_d;
  logic             neg_q, neg_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             stb_q, stb_d;
  logic [3:0]       ckey_q, ckey_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             key_evt;
  logic             is_digit;
  logic             timeout_hit;

  // Appending a digit shifts the operand left one decimal place; the oldest
  // digit falls off so the operand always fits in MAX_DIGITS digits.
  function automatic logic [6:0] shift_in(input logic [6:0] v, input logic [3:0] d);
    int unsigned t;
    t = (32'(v) % DIGIT_MOD) * 10 + 32'(d);
    return 7'(t);
  endfunction

  // A press is the first cycle key_valid is seen high, so holding a key
  // produces exactly one event.
  assign key_evt  = bus.key_valid & ~key_prev_q;
  assign is_digit = (bus.key_code <= 4'd9);

  // The timeout fires on the cycle the counter would reach CALC_TIMEOUT, so
  // SHOW is entered CALC_TIMEOUT cycles after WAIT is entered.
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == CNT_W'(CALC_TIMEOUT));

  // Next-state and datapath decisions. Every register holds by default; only
  // the crono strobe defaults low so it stays a single-cycle pulse.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    op_d     = op_q;
    result_d = result_q;
    neg_d    = neg_q;
    valid_d  = valid_q;
    error_d  = error_q;
    stb_d    = 1'b0;
    ckey_d   = ckey_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      CRONO: begin
        if (key_evt) begin
          if (bus.key_code == KEY_STAR) begin
            state_d = EDIT_X;
          end else begin
            stb_d  = 1'b1;
            ckey_d = bus.key_code;
          end
        end
      end

      EDIT_X, EDIT_Y: begin
        if (key_evt) begin
          if (is_digit) begin
            if (state_q == EDIT_X) x_d = shift_in(x_q, bus.key_code);
            else                   y_d = shift_in(y_q, bus.key_code);
          end else begin
            case (bus.key_code)
              KEY_A:    op_d = op_q + 2'd1;
              KEY_B:    state_d = (state_q == EDIT_X) ? EDIT_Y : EDIT_X;
              KEY_C: begin
                if (state_q == EDIT_X) x_d = '0;
                else                   y_d = '0;
              end
              KEY_HASH: state_d = START;
              KEY_D:    state_d = CRONO;
              default:  ;
            endcase
          end
        end
      end

      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end

      // An abort with D takes priority over a coincident calc_done.
      WAIT: begin
        cnt_d = cnt_inc;
        if (key_evt && bus.key_code == KEY_D) begin
          state_d = CRONO;
        end else if (bus.calc_done) begin
          result_d = bus.calc_result;
          neg_d    = bus.calc_sign;
          valid_d  = 1'b1;
          error_d  = 1'b0;
          state_d  = SHOW;
        end else if (timeout_hit) begin
          valid_d = 1'b0;
          error_d = 1'b1;
          state_d = SHOW;
        end
      end

      // Every exit from SHOW drops the result flags so they only ever
      // describe the result currently on display.
      SHOW: begin
        if (key_evt) begin
          case (bus.key_code)
            KEY_C: begin
              x_d     = '0;
              y_d     = '0;
              op_d    = '0;
              valid_d = 1'b0;
              error_d = 1'b0;
              state_d = EDIT_X;
            end
            KEY_STAR: begin
              valid_d = 1'b0;
              error_d = 1'b0;
              state_d = EDIT_X;
            end
            KEY_D: begin
              valid_d = 1'b0;
              error_d = 1'b0;
              state_d = CRONO;
            end
            KEY_HASH: begin
              valid_d = 1'b0;
              error_d = 1'b0;
              state_d = START;
            end
            default: ;
          endcase
        end
      end

      default: state_d = CRONO;
    endcase
  end

  // State and datapath registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CRONO;
      key_prev_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      neg_q      <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      stb_q      <= 1'b0;
      ckey_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= bus.key_valid;
      x_q        <= x_d;
      y_q        <= y_d;
      op_q       <= op_d;
      result_q   <= result_d;
      neg_q      <= neg_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      stb_q      <= stb_d;
      ckey_q     <= ckey_d;
      cnt_q      <= cnt_d;
    end
  end

  // Mode, LEDs and the start pulse are decoded straight from the state so
  // they follow it exactly, including the single START cycle.
  assign bus.mode         = (state_q != CRONO);
  assign bus.led_x        = (state_q == EDIT_X);
  assign bus.led_y        = (state_q == EDIT_Y);
  assign bus.calc_start   = (state_q == START);
  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.op           = op_q;
  assign bus.result       = result_q;
  assign bus.result_neg   = neg_q;
  assign bus.result_valid = valid_q;
  assign bus.error        = error_q;
  assign bus.crono_stb    = stb_q;
  assign bus.crono_key    = ckey_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_sequencer
// Purpose : randomized scoreboard bench for calc_sequencer. Key presses and
//           calculator responses update a phase-level model of the keypad
//           calculator; expected strobes, start pulses and result displays
//           are queued and matched by an independent monitor.
// ---------------------------------------------------------------------------
module tb_calc_sequencer;

  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst_n;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  calc_sequencer_if bus();

  calc_sequencer #(.CALC_TIMEOUT(TIMEOUT), .MAX_DIGITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model phases: the calculator is either forwarding to the stopwatch,
  // editing operands, busy computing, or showing an outcome.
  typedef enum {M_CRONO, M_EDIT, M_BUSY, M_SHOW} mphase_e;

  mphase_e mPhase;
  bit      mEditY;
  int      mX, mY, mOp, mResult, mNeg, mCronoKey;
  bit      mValid, mError;

  // Expected DUT events: kind 0 = crono strobe (a=key), kind 1 = calc start
  // (a=x, b=y, c=op), kind 2 = result display (a=valid, b=error, c=result,
  // d=sign, delay = cycles after calc_start or -1 when not checked).
  typedef struct {
    int kind;
    int a;
    int b;
    int c;
    int d;
    int delay;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lastStartCyc = 0;

  // One comparison against the model.
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic pushExp(input int kind, input int a, input int b, input int c,
                         input int d, input int delay);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c; e.d = d; e.delay = delay;
    sbq.push_back(e);
  endtask

  task automatic modelReset();
    mPhase = M_CRONO; mEditY = 0;
    mX = 0; mY = 0; mOp = 0;
    mResult = 0; mNeg = 0; mCronoKey = 0;
    mValid = 0; mError = 0;
  endtask

  // A finished calculation only counts while the calculator is busy.
  task automatic modelDone(input int res, input int neg);
    if (mPhase == M_BUSY) begin
      mPhase = M_SHOW; mValid = 1; mError = 0;
      mResult = res; mNeg = neg;
      pushExp(2, 1, 0, res, neg, -1);
    end
  endtask

  // Keypad meaning of one press in each phase.
  task automatic modelKey(input int code, input bit withDone, input int res, input int neg);
    case (mPhase)
      M_CRONO: begin
        if (code == 14) begin
          mPhase = M_EDIT; mEditY = 0;
        end else begin
          mCronoKey = code;
          pushExp(0, code, 0, 0, 0, -1);
        end
      end
      M_EDIT: begin
        if (code <= 9) begin
          if (mEditY) mY = (mY % 10) * 10 + code;
          else        mX = (mX % 10) * 10 + code;
        end else if (code == 10) mOp = (mOp + 1) % 4;
        else if (code == 11) mEditY = !mEditY;
        else if (code == 12) begin
          if (mEditY) mY = 0; else mX = 0;
        end else if (code == 13) mPhase = M_CRONO;
        else if (code == 15) begin
          mPhase = M_BUSY;
          pushExp(1, mX, mY, mOp, 0, -1);
        end
      end
      M_BUSY: begin
        if (code == 13) mPhase = M_CRONO;
        else if (withDone) modelDone(res, neg);
      end
      M_SHOW: begin
        if (code == 12) begin
          mX = 0; mY = 0; mOp = 0; mPhase = M_EDIT; mEditY = 0;
        end else if (code == 14) begin
          mPhase = M_EDIT; mEditY = 0;
        end else if (code == 13) mPhase = M_CRONO;
        else if (code == 15) begin
          mPhase = M_BUSY;
          pushExp(1, mX, mY, mOp, 0, -1);
        end
      end
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press a key for 'hold' cycles, optionally with a coincident calc_done,
  // then release it for one cycle. Called and returns on a falling edge.
  task automatic applyStimulus(input int code, input int hold, input bit withDone,
                               input int res, input int neg);
    bus.key_code    = 4'(code);
    bus.key_valid   = 1'b1;
    bus.calc_done   = withDone;
    bus.calc_result = 14'(res);
    bus.calc_sign   = 1'(neg);
    modelKey(code, withDone, res, neg);
    @(negedge clk);
    bus.calc_done = 1'b0;
    repeat (hold - 1) @(negedge clk);
    bus.key_valid = 1'b0;
    @(negedge clk);
  endtask

  // One-cycle calc_done pulse from the calculator.
  task automatic pulseDone(input int res, input int neg);
    bus.calc_result = 14'(res);
    bus.calc_sign   = 1'(neg);
    bus.calc_done   = 1'b1;
    modelDone(res, neg);
    @(negedge clk);
    bus.calc_done = 1'b0;
    @(negedge clk);
  endtask

  // Let the calculator stay silent; the display must show an error after
  // exactly the timeout, keeping the old result.
  task automatic waitTimeout();
    int n;
    if (mPhase == M_BUSY) begin
      mPhase = M_SHOW; mValid = 0; mError = 1;
      pushExp(2, 0, 1, mResult, mNeg, TIMEOUT + 1);
    end
    n = 0;
    while (sbq.size() != 0 && n < TIMEOUT + 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_show_reached", sbq.size(), 0);
    idle(1);
  endtask

  // Compare every steady output against the model.
  task automatic checkOutput();
    check("mode",         int'(bus.mode),         int'(mPhase != M_CRONO));
    check("led_x",        int'(bus.led_x),        int'(mPhase == M_EDIT && !mEditY));
    check("led_y",        int'(bus.led_y),        int'(mPhase == M_EDIT && mEditY));
    check("x",            int'(bus.x),            mX);
    check("y",            int'(bus.y),            mY);
    check("op",           int'(bus.op),           mOp);
    check("calc_start",   int'(bus.calc_start),   0);
    check("crono_stb",    int'(bus.crono_stb),    0);
    check("crono_key",    int'(bus.crono_key),    mCronoKey);
    check("result",       int'(bus.result),       mResult);
    check("result_neg",   int'(bus.result_neg),   mNeg);
    check("result_valid", int'(bus.result_valid), int'(mPhase == M_SHOW && mValid));
    check("error",        int'(bus.error),        int'(mPhase == M_SHOW && mError));
  endtask

  // Match one observed DUT event against the oldest expectation.
  task automatic handleEvent(input int kind);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event kind=%0d actual=present expected=none", kind);
    end else begin
      e = sbq.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        case (kind)
          0: check("stb_key", int'(bus.crono_key), e.a);
          1: begin
            check("start_x",  int'(bus.x),  e.a);
            check("start_y",  int'(bus.y),  e.b);
            check("start_op", int'(bus.op), e.c);
          end
          default: begin
            check("show_valid",  int'(bus.result_valid), e.a);
            check("show_error",  int'(bus.error),        e.b);
            check("show_result", int'(bus.result),       e.c);
            check("show_neg",    int'(bus.result_neg),   e.d);
            if (e.delay >= 0) check("timeout_latency", cyc - lastStartCyc, e.delay);
          end
        endcase
      end
    end
  endtask

  // Monitor: watches the DUT on falling edges for strobes, start pulses and
  // newly displayed results, independent of the stimulus thread.
  initial begin : monitor
    bit prevStart;
    bit prevShow;
    bit showNow;
    prevStart = 0;
    prevShow  = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.crono_stb) handleEvent(0);
      if (bus.calc_start) begin
        check("start_single_cycle", int'(prevStart), 0);
        lastStartCyc = cyc;
        handleEvent(1);
      end
      showNow = bus.result_valid | bus.error;
      if (showNow && !prevShow) handleEvent(2);
      prevStart = bus.calc_start;
      prevShow  = showNow;
    end
  end

  // Finish any calculation the random walk started: abort, or deliver a
  // result within a few cycles.
  task automatic resolveBusy();
    int r;
    r = $urandom_range(0, 4);
    if (r == 0) begin
      applyStimulus(13, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 16383), $urandom_range(0, 1));
    end else begin
      if (r == 1) applyStimulus($urandom_range(0, 12), 1, 0, 0, 0);
      idle($urandom_range(0, 6));
      pulseDone($urandom_range(0, 16383), $urandom_range(0, 1));
    end
  endtask

  // Safety net so the run always ends.
  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios first, then a random walk, then a reset mid-WAIT.
  initial begin : stimulus
    int code;
    rst_n           = 1'b0;
    bus.key_valid   = 1'b0;
    bus.key_code    = 4'd0;
    bus.calc_done   = 1'b0;
    bus.calc_result = 14'd0;
    bus.calc_sign   = 1'b0;
    modelReset();
    idle(3);
    checkOutput();
    rst_n = 1'b1;
    idle(1);

    $display("[TB] stopwatch forwarding");
    applyStimulus(5, 1, 0, 0, 0);
    checkOutput();

    $display("[TB] operand entry");
    applyStimulus(14, 1, 0, 0, 0);
    applyStimulus(4, 1, 0, 0, 0);
    applyStimulus(2, 2, 0, 0, 0);
    checkOutput();
    applyStimulus(7, 1, 0, 0, 0);
    checkOutput();

    $display("[TB] calculation with done");
    applyStimulus(14, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(2, 1, 0, 0, 0);
    applyStimulus(11, 1, 0, 0, 0);
    applyStimulus(3, 1, 0, 0, 0);
    applyStimulus(10, 1, 0, 0, 0);
    applyStimulus(10, 1, 0, 0, 0);
    checkOutput();
    applyStimulus(15, 1, 0, 0, 0);
    idle(1);
    pulseDone(100, 0);
    checkOutput();

    $display("[TB] calculation timeout");
    applyStimulus(15, 1, 0, 0, 0);
    waitTimeout();
    checkOutput();

    $display("[TB] held key and abort");
    applyStimulus(14, 1, 0, 0, 0);
    applyStimulus(11, 1, 0, 0, 0);
    applyStimulus(9, 50, 0, 0, 0);
    checkOutput();
    applyStimulus(15, 1, 0, 0, 0);
    applyStimulus(5, 1, 0, 0, 0);
    applyStimulus(10, 1, 0, 0, 0);
    applyStimulus(13, 1, 1, 555, 1);
    checkOutput();

    $display("[TB] random walk");
    for (int s = 0; s < 250; s++) begin
      code = $urandom_range(0, 15);
      if (mPhase == M_CRONO && $urandom_range(0, 3) == 0) code = 14;
      applyStimulus(code, $urandom_range(1, 3), 0, 0, 0);
      if (mPhase == M_BUSY) resolveBusy();
      if (mPhase != M_BUSY && $urandom_range(0, 9) == 0)
        pulseDone($urandom_range(0, 16383), $urandom_range(0, 1));
      checkOutput();
    end

    $display("[TB] reset during wait");
    if (mPhase != M_EDIT) applyStimulus(14, 1, 0, 0, 0);
    if (mPhase == M_CRONO) applyStimulus(14, 1, 0, 0, 0);
    applyStimulus(15, 1, 0, 0, 0);
    idle(3);
    rst_n = 1'b0;
    #1;
    modelReset();
    check("rst_mode",         int'(bus.mode),         0);
    check("rst_x",            int'(bus.x),            0);
    check("rst_y",            int'(bus.y),            0);
    check("rst_op",           int'(bus.op),           0);
    check("rst_calc_start",   int'(bus.calc_start),   0);
    check("rst_result",       int'(bus.result),       0);
    check("rst_result_neg",   int'(bus.result_neg),   0);
    check("rst_result_valid", int'(bus.result_valid), 0);
    check("rst_error",        int'(bus.error),        0);
    check("rst_led_x",        int'(bus.led_x),        0);
    check("rst_led_y",        int'(bus.led_y),        0);
    check("rst_crono_stb",    int'(bus.crono_stb),    0);
    check("rst_crono_key",    int'(bus.crono_key),    0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    checkOutput();

    check("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
